mem_req_ctrl: RTL and testbench

//  Request front-end sitting directly upstream of the memory model: accepts read/write commands on a

---
 rtl/mem_ctrl_pkg.sv | 33 +++
 rtl/mem_req_ctrl_if.sv | 51 +++++
 rtl/mem_ctrl_fifo.sv | 70 +++++++
 rtl/mem_req_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared types and constants for the memory request front-end.
//   DEF_*          default widths/depths used as parameter defaults
//   cmd_t          command word at default widths {wr, addr, wdata}
//   ctrl_state_e   issue FSM states
//   sat_inc16      16-bit saturating increment used by the optional stats
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_CMD_DEPTH = 4;
  localparam int DEF_RSP_DEPTH = 4;
  localparam int DEF_RD_LAT    = 1;

  typedef struct packed {
    logic                  wr;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ISSUE       = 2'd1,
    WAIT_CREDIT = 2'd2
  } ctrl_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : (value + 16'd1);
  endfunction

endpackage

// File: rtl/mem_req_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_req_ctrl_if
// Bundles the command stream, the response stream and the memory pins.
//   req_valid/req_ready/req_wr/req_addr/req_wdata   command stream
//   rsp_valid/rsp_ready/rsp_rdata                   read response stream
//   mem_rd_en/mem_wr_en/mem_addr/mem_wdata          pins toward memory
//   mem_rdata                                       read data from memory
// Modports:
//   slave  - controller view (consumes commands, produces responses, drives memory)
//   master - environment view (traffic source, response sink and memory model)
// -----------------------------------------------------------------------------
interface mem_req_ctrl_if #(
  parameter int ADDR_W = mem_ctrl_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_ctrl_pkg::DEF_DATA_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata,
    input  rsp_ready,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata,
    output rsp_ready,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// mem_ctrl_fifo
// Synchronous FIFO with synchronous active-low reset and an occupancy count.
// Head data is presented combinationally; push when full and pop when empty
// are ignored.
//   clk    clock
//   reset  synchronous active-low reset (empties the FIFO)
//   push   write din
//   pop    advance head
//   din    write data
//   dout   head entry
//   count  number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module mem_ctrl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push && (count_r != CNT_W'(DEPTH));
  assign do_pop_s  = pop && (count_r != CNT_W'(0));
  assign dout      = store_r[rd_ptr_r];
  assign count     = count_r;

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (reset && do_push_s) begin
      store_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// -----------------------------------------------------------------------------
// mem_req_ctrl
// Request front-end for a simple synchronous memory. Commands are queued in a
// command FIFO and issued in order, one per cycle, as registered rd_en/wr_en
// pulses. Read data is captured RD_LAT cycles after each rd_en pulse into a
// response FIFO and returned in issue order. Reads only issue while
// (in-flight reads + buffered responses) < RSP_DEPTH, so the response FIFO
// can never overflow.
// Ports:
//   clk     clock, rising edge
//   reset   synchronous active-low reset; drops queued and in-flight commands
//   bus     mem_req_ctrl_if.slave (command stream, response stream, memory pins)
//   stat_rd_cnt / stat_wr_cnt  (only with MEM_REQ_CTRL_STATS_EN defined)
//           saturating 16-bit counts of issued reads / writes
// Optional build macro: MEM_REQ_CTRL_STATS_EN
// -----------------------------------------------------------------------------
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CMD_DEPTH = DEF_CMD_DEPTH,
  parameter int RSP_DEPTH = DEF_RSP_DEPTH,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic                clk,
  input  logic                reset,
  mem_req_ctrl_if.slave       bus
`ifdef MEM_REQ_CTRL_STATS_EN
  ,
  output logic [15:0]         stat_rd_cnt,
  output logic [15:0]         stat_wr_cnt
`endif
);

  localparam int CMD_W  = 1 + ADDR_W + DATA_W;
  localparam int CCNT_W = $clog2(CMD_DEPTH) + 1;
  localparam int RCNT_W = $clog2(RSP_DEPTH) + 1;
  localparam int SUM_W  = RCNT_W + 1;

  // Command word at this instance's widths
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_word_t;

  ctrl_state_e       state_r;
  ctrl_state_e       state_nxt_s;

  cmd_word_t         cmd_in_s;
  cmd_word_t         cmd_head_s;
  logic [CMD_W-1:0]  cmd_head_vec_s;
  logic [CCNT_W-1:0] cmd_count_s;
  logic              cmd_push_s;
  logic              cmd_pop_s;
  logic              cmd_empty_s;
  logic              cmd_full_s;

  logic [DATA_W-1:0] rsp_head_s;
  logic [RCNT_W-1:0] rsp_count_s;
  logic              rsp_push_s;
  logic              rsp_pop_s;
  logic              rsp_valid_s;

  logic              issue_rd_s;
  logic              issue_wr_s;
  logic              head_go_s;
  logic              credit_ok_s;
  logic [SUM_W-1:0]  credit_sum_s;
  logic [RCNT_W-1:0] inflight_r;
  logic [RD_LAT-1:0] rd_pipe_r;

  logic              mem_rd_en_r;
  logic              mem_wr_en_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  assign cmd_in_s    = {bus.req_wr, bus.req_addr, bus.req_wdata};
  assign cmd_head_s  = cmd_word_t'(cmd_head_vec_s);
  assign cmd_full_s  = (cmd_count_s == CCNT_W'(CMD_DEPTH));
  assign cmd_empty_s = (cmd_count_s == CCNT_W'(0));
  // Ready is held low through reset so nothing is accepted into a FIFO being cleared
  assign bus.req_ready = reset && !cmd_full_s;
  assign cmd_push_s    = bus.req_valid && bus.req_ready;
  assign cmd_pop_s     = issue_rd_s || issue_wr_s;

  mem_ctrl_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_push_s),
    .pop   (cmd_pop_s),
    .din   (cmd_in_s),
    .dout  (cmd_head_vec_s),
    .count (cmd_count_s)
  );

  // ---------------------------------------------------------------------------
  // Response FIFO, fed by the read-latency shift register
  // ---------------------------------------------------------------------------
  assign rsp_push_s    = rd_pipe_r[RD_LAT-1];
  assign rsp_valid_s   = (rsp_count_s != RCNT_W'(0));
  assign rsp_pop_s     = rsp_valid_s && bus.rsp_ready;
  assign bus.rsp_valid = rsp_valid_s;
  // Head entry is stable until popped; forced to zero when nothing is buffered
  assign bus.rsp_rdata = rsp_valid_s ? rsp_head_s : {DATA_W{1'b0}};

  mem_ctrl_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rsp_push_s),
    .pop   (rsp_pop_s),
    .din   (bus.mem_rdata),
    .dout  (rsp_head_s),
    .count (rsp_count_s)
  );

  // ---------------------------------------------------------------------------
  // Credit: every read already issued but not yet buffered, plus every buffered
  // response, holds one response FIFO slot.
  // ---------------------------------------------------------------------------
  assign credit_sum_s = {1'b0, inflight_r} + {1'b0, rsp_count_s};
  assign credit_ok_s  = (credit_sum_s < SUM_W'(RSP_DEPTH));
  assign head_go_s    = !cmd_empty_s && (cmd_head_s.wr || credit_ok_s);

  // Next-state and issue decision; the head is issued in the same cycle the
  // FSM leaves IDLE so an empty pipe costs no extra cycle
  always_comb begin
    state_nxt_s = state_r;
    issue_rd_s  = 1'b0;
    issue_wr_s  = 1'b0;
    case (state_r)
      IDLE, ISSUE, WAIT_CREDIT: begin
        if (cmd_empty_s) begin
          state_nxt_s = IDLE;
        end else if (head_go_s) begin
          state_nxt_s = ISSUE;
          issue_wr_s  = cmd_head_s.wr;
          issue_rd_s  = !cmd_head_s.wr;
        end else begin
          state_nxt_s = WAIT_CREDIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered memory pins: one enable pulse per popped command, address and
  // write data hold their last value between issues
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_rd_en_r <= 1'b0;
      mem_wr_en_r <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      mem_rd_en_r <= issue_rd_s;
      mem_wr_en_r <= issue_wr_s;
      if (cmd_pop_s) begin
        mem_addr_r <= cmd_head_s.addr;
      end
      if (issue_wr_s) begin
        mem_wdata_r <= cmd_head_s.wdata;
      end
    end
  end

  assign bus.mem_rd_en = mem_rd_en_r;
  assign bus.mem_wr_en = mem_wr_en_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

  // Read-latency shift: tap RD_LAT-1 marks the cycle mem_rdata is valid
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_pipe_r <= {RD_LAT{1'b0}};
    end else begin
      rd_pipe_r[0] <= mem_rd_en_r;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe_r[i] <= rd_pipe_r[i-1];
      end
    end
  end

  // In-flight read counter: up on read issue, down when its data is buffered
  always_ff @(posedge clk) begin
    if (!reset) begin
      inflight_r <= RCNT_W'(0);
    end else begin
      case ({issue_rd_s, rsp_push_s})
        2'b10:   inflight_r <= inflight_r + RCNT_W'(1);
        2'b01:   inflight_r <= inflight_r - RCNT_W'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

`ifdef MEM_REQ_CTRL_STATS_EN
  logic [15:0] stat_rd_cnt_r;
  logic [15:0] stat_wr_cnt_r;

  // Saturating issue counters, advanced on the edge that raises each enable
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_rd_cnt_r <= 16'd0;
      stat_wr_cnt_r <= 16'd0;
    end else begin
      if (issue_rd_s) begin
        stat_rd_cnt_r <= sat_inc16(stat_rd_cnt_r);
      end
      if (issue_wr_s) begin
        stat_wr_cnt_r <= sat_inc16(stat_wr_cnt_r);
      end
    end
  end

  assign stat_rd_cnt = stat_rd_cnt_r;
  assign stat_wr_cnt = stat_wr_cnt_r;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_req_ctrl
// Directed bench for mem_req_ctrl with a one-cycle-latency memory model.
// Inputs change 1 ns after the rising edge; pins are observed on the falling
// edge. Stats checks are built only with MEM_REQ_CTRL_STATS_EN.
// -----------------------------------------------------------------------------
module tb_mem_req_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int rd_pulses = 0;
  int rsp_rise_cyc = 0;
  logic rsp_valid_prev = 1'b0;

  logic [31:0] mem_model [256];
  logic [7:0]  wr_addr_q [$];
  int          wr_cyc_q  [$];
  logic [31:0] rsp_q     [$];

  mem_req_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bus ();

`ifdef MEM_REQ_CTRL_STATS_EN
  logic [15:0] stat_rd_cnt;
  logic [15:0] stat_wr_cnt;
`endif

  mem_req_ctrl #(
    .ADDR_W(8), .DATA_W(32), .CMD_DEPTH(4), .RSP_DEPTH(4), .RD_LAT(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MEM_REQ_CTRL_STATS_EN
    ,
    .stat_rd_cnt (stat_rd_cnt),
    .stat_wr_cnt (stat_wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Edge counter
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: write on wr_en, registered read data on rd_en
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem_model[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd_en) bus.mem_rdata <= mem_model[bus.mem_addr];
  end

  // Pin and response monitor
  always @(negedge clk) begin
    if (bus.mem_rd_en) rd_pulses <= rd_pulses + 1;
    if (bus.mem_wr_en) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_cyc_q.push_back(cyc);
    end
    if (bus.rsp_valid && bus.rsp_ready && reset) rsp_q.push_back(bus.rsp_rdata);
    if (bus.rsp_valid && !rsp_valid_prev) rsp_rise_cyc <= cyc;
    rsp_valid_prev <= bus.rsp_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command and hold it until accepted; acc = accepting edge index
  task automatic send(input logic wr, input logic [7:0] a, input logic [31:0] d, output int acc);
    bit done;
    done = 1'b0;
    acc = -1;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    for (int i = 0; i < 200 && !done; i++) begin
      if (bus.req_ready) begin
        acc  = cyc + 1;
        done = 1'b1;
      end
      tick();
    end
    bus.req_valid = 1'b0;
    check("send_accept", 64'(done), 64'(1));
  endtask

  task automatic wait_rsp(input string tag, input int n);
    for (int i = 0; i < 200 && rsp_q.size() < n; i++) tick();
    check(tag, 64'(rsp_q.size()), 64'(n));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    check({tag, "_rd_en"},     64'(bus.mem_rd_en), 64'(0));
    check({tag, "_wr_en"},     64'(bus.mem_wr_en), 64'(0));
    check({tag, "_addr"},      64'(bus.mem_addr),  64'(0));
    check({tag, "_wdata"},     64'(bus.mem_wdata), 64'(0));
    check({tag, "_rdata"},     64'(bus.rsp_rdata), 64'(0));
  endtask

  initial begin
    int acc;
    int base_rsp;
    int base_rd;
    int base_wr;

    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b1;
    repeat (3) tick();
    check_outputs_zero("reset");
    reset = 1'b1;
    tick();
    check("reset_ready_after", 64'(bus.req_ready), 64'(1));
    check("reset_state_idle", 64'(dut.state_r), 64'(IDLE));

    // 1: write then read the same address, 3-cycle read latency
    base_rsp = rsp_q.size();
    send(1'b1, 8'h10, 32'hA5A5_0001, acc);
    send(1'b0, 8'h10, 32'h0, acc);
    wait_rsp("t1_rsp_cnt", base_rsp + 1);
    check("t1_rdata", 64'(rsp_q[base_rsp]), 64'hA5A5_0001);
    check("t1_latency", 64'(rsp_rise_cyc - acc), 64'(3));

    // 3: eight back-to-back writes, addr i <- 0x100+i
    repeat (3) tick();
    base_wr = wr_addr_q.size();
    for (int i = 0; i < 8; i++) send(1'b1, 8'(i), 32'h100 + 32'(i), acc);
    repeat (4) tick();
    check("t3_wr_cnt", 64'(wr_addr_q.size() - base_wr), 64'(8));
    for (int i = 0; i < 8; i++) begin
      check("t3_wr_addr", 64'(wr_addr_q[base_wr + i]), 64'(i));
      check("t3_wr_consec", 64'(wr_cyc_q[base_wr + i] - wr_cyc_q[base_wr]), 64'(i));
    end
    check("t3_addr_hold", 64'(bus.mem_addr), 64'h07);

    // 2: responses blocked, eight reads -> four issue, FIFO fills
    bus.rsp_ready = 1'b0;
    base_rsp = rsp_q.size();
    base_rd  = rd_pulses;
    for (int i = 0; i < 8; i++) send(1'b0, 8'(i), 32'h0, acc);
    repeat (10) tick();
    check("t2_rd_pulses", 64'(rd_pulses - base_rd), 64'(4));
    check("t2_state", 64'(dut.state_r), 64'(WAIT_CREDIT));
    check("t2_req_ready", 64'(bus.req_ready), 64'(0));
    check("t2_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    check("t2_rdata_held", 64'(bus.rsp_rdata), 64'h100);
    bus.rsp_ready = 1'b1;
    wait_rsp("t2_rsp_cnt", base_rsp + 8);
    for (int i = 0; i < 8; i++) begin
      check("t2_rdata", 64'(rsp_q[base_rsp + i]), 64'h100 + 64'(i));
    end
    check("t2_rd_total", 64'(rd_pulses - base_rd), 64'(8));

    // 5: write then immediate read of the same address
    base_rsp = rsp_q.size();
    send(1'b1, 8'h20, 32'h1, acc);
    send(1'b0, 8'h20, 32'h0, acc);
    wait_rsp("t5_rsp_cnt", base_rsp + 1);
    check("t5_rdata", 64'(rsp_q[base_rsp]), 64'h1);

    // 4: reset with two reads in flight
    send(1'b1, 8'h30, 32'hDEAD_BEEF, acc);
    repeat (5) tick();
    base_rsp = rsp_q.size();
    base_rd  = rd_pulses;
    send(1'b0, 8'h30, 32'h0, acc);
    send(1'b0, 8'h30, 32'h0, acc);
    tick();
    reset = 1'b0;
    tick();
    check_outputs_zero("t4");
    reset = 1'b1;
    repeat (10) tick();
    check("t4_no_rsp", 64'(rsp_q.size()), 64'(base_rsp));
    check("t4_rd_pulses", 64'(rd_pulses - base_rd), 64'(2));
    send(1'b0, 8'h30, 32'h0, acc);
    wait_rsp("t4_rsp_cnt", base_rsp + 1);
    check("t4_rdata", 64'(rsp_q[base_rsp]), 64'hDEAD_BEEF);

`ifdef MEM_REQ_CTRL_STATS_EN
    // 6: counters from a clean reset
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("t6_rd_cleared", 64'(stat_rd_cnt), 64'(0));
    for (int i = 0; i < 3; i++) send(1'b1, 8'h50 + 8'(i), 32'h7 + 32'(i), acc);
    for (int i = 0; i < 2; i++) send(1'b0, 8'h50 + 8'(i), 32'h0, acc);
    repeat (10) tick();
    check("t6_wr_cnt", 64'(stat_wr_cnt), 64'(3));
    check("t6_rd_cnt", 64'(stat_rd_cnt), 64'(2));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
